moore_parity_window: RTL and testbench

Parametrised Moore parity tracker for serial bit streams. It accepts qualified serial bits in fixed-length frames of `WINDOW` bits and classifies each completed frame as even or odd parity (count of ones). Per-class frame counts are kept in saturating counters. It is the generalised successor of the single-bit odd/even Moore example and sits after any serial source that provides a frame-start strobe.

---
 rtl/moore_parity_window.sv | 133 +++++++++++++
 tb/tb_moore_parity_window.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/moore_parity_window.sv
// Moore parity tracker: classifies fixed WINDOW-bit frames as even/odd with saturating counts.
// Optional parity expectation checking is enabled by defining PARITY_CHK_EN.
module moore_parity_window #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         fim_par,
    output logic                         fim_impar,
    output logic                         frame_done,
    output logic                         busy,
    output logic [$clog2(WINDOW+1)-1:0]  ones,
    output logic [CNT_W-1:0]             par_frames,
    output logic [CNT_W-1:0]             impar_frames
`ifdef PARITY_CHK_EN
   ,input  logic                         exp_odd,
    output logic                         par_err,
    output logic [CNT_W-1:0]             err_frames
`endif
);

    localparam int unsigned OW = $clog2(WINDOW + 1);

    typedef enum logic [2:0] {
        IDLE,
        EVEN,
        ODD,
        DONE_EVEN,
        DONE_ODD
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0] par_q, par_d;
    logic [CNT_W-1:0] impar_q, impar_d;
    logic             nxt_odd;
`ifdef PARITY_CHK_EN
    logic             exp_odd_q, exp_odd_d;
    logic [CNT_W-1:0] err_q, err_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        par_d   = par_q;
        impar_d = impar_q;
        nxt_odd = 1'b0;
`ifdef PARITY_CHK_EN
        exp_odd_d = exp_odd_q;
        err_d     = err_q;
`endif
        // start has priority in every state: restart, abort or back-to-back
        if (start) begin
            state_d = EVEN;
            cnt_d   = '0;
            ones_d  = '0;
`ifdef PARITY_CHK_EN
            exp_odd_d = exp_odd;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                EVEN, ODD: begin
                    if (in_valid) begin
                        nxt_odd = (state_q == ODD) ^ in;
                        ones_d  = ones_q + OW'(in);
                        if (cnt_q == OW'(WINDOW - 1)) begin
                            cnt_d   = '0;
                            state_d = nxt_odd ? DONE_ODD : DONE_EVEN;
                            if (nxt_odd) impar_d = sat_inc(impar_q);
                            else         par_d   = sat_inc(par_q);
`ifdef PARITY_CHK_EN
                            if (nxt_odd != exp_odd_q) err_d = sat_inc(err_q);
`endif
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = nxt_odd ? ODD : EVEN;
                        end
                    end
                end
                DONE_EVEN, DONE_ODD: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
            par_q   <= '0;
            impar_q <= '0;
`ifdef PARITY_CHK_EN
            exp_odd_q <= 1'b0;
            err_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            par_q   <= par_d;
            impar_q <= impar_d;
`ifdef PARITY_CHK_EN
            exp_odd_q <= exp_odd_d;
            err_q     <= err_d;
`endif
        end
    end

    assign fim_par      = (state_q == DONE_EVEN);
    assign fim_impar    = (state_q == DONE_ODD);
    assign frame_done   = fim_par | fim_impar;
    assign busy         = (state_q == EVEN) || (state_q == ODD);
    assign ones         = ones_q;
    assign par_frames   = par_q;
    assign impar_frames = impar_q;
`ifdef PARITY_CHK_EN
    assign par_err      = (fim_par & exp_odd_q) | (fim_impar & ~exp_odd_q);
    assign err_frames   = err_q;
`endif

endmodule

// File: tb/tb_moore_parity_window.sv
// Directed scoreboard bench for moore_parity_window (WINDOW=8, CNT_W=2, default build).
module tb_moore_parity_window;

    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_b;
    logic          fim_par;
    logic          fim_impar;
    logic          frame_done;
    logic          busy;
    logic [3:0]    ones;
    logic [CW-1:0] par_frames;
    logic [CW-1:0] impar_frames;

    always #5 clk = ~clk;

    moore_parity_window #(.WINDOW(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in           (in_b),
        .fim_par      (fim_par),
        .fim_impar    (fim_impar),
        .frame_done   (frame_done),
        .busy         (busy),
        .ones         (ones),
        .par_frames   (par_frames),
        .impar_frames (impar_frames)
    );

    typedef struct {
        logic odd;
        int   n_ones;
        int   par;
        int   impar;
    } exp_t;

    exp_t sb[$];
    int   done_cycs[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_par = 0;
    int   exp_impar = 0;
    int   s;
    int   n;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    task automatic observe();
        exp_t e;
        chk("done_is_or", {31'b0, frame_done}, {31'b0, fim_par | fim_impar});
        if (fim_par || fim_impar) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, fim_par | fim_impar}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("fim_par", {31'b0, fim_par}, {31'b0, ~e.odd});
                chk("fim_impar", {31'b0, fim_impar}, {31'b0, e.odd});
                chk("ones_at_done", {28'b0, ones}, e.n_ones);
                chk("par_frames", {30'b0, par_frames}, e.par);
                chk("impar_frames", {30'b0, impar_frames}, e.impar);
                done_cycs.push_back(cyc);
            end
        end
    endtask

    task automatic step(input logic st, input logic v, input logic b);
        start    = st;
        in_valid = v;
        in_b     = b;
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic push_exp(input logic [7:0] bits);
        exp_t e;
        e.odd    = ^bits;
        e.n_ones = $countones(bits);
        if (e.odd) exp_impar = (exp_impar < CMAX) ? exp_impar + 1 : CMAX;
        else       exp_par   = (exp_par   < CMAX) ? exp_par   + 1 : CMAX;
        e.par   = exp_par;
        e.impar = exp_impar;
        sb.push_back(e);
    endtask

    // bits[7] is sent first; gaps inserts an in_valid=0 cycle (with in=1) between bits
    task automatic send_frame(input logic [7:0] bits, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps && i != 7) step(1'b0, 1'b0, 1'b1);
            if (i == 0) push_exp(bits);
            step(1'b0, 1'b1, bits[i]);
        end
    endtask

    initial begin
        start = 1'b0; in_valid = 1'b0; in_b = 1'b0; rst = 1'b0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, frame_done}, 32'd0);
        chk("rst_fim_par", {31'b0, fim_par}, 32'd0);
        chk("rst_fim_impar", {31'b0, fim_impar}, 32'd0);
        chk("rst_ones", {28'b0, ones}, 32'd0);
        chk("rst_par", {30'b0, par_frames}, 32'd0);
        chk("rst_impar", {30'b0, impar_frames}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // odd frame, continuous valid
        step(1'b1, 1'b0, 1'b0);
        s = cyc;
        chk("t1_busy_after_start", {31'b0, busy}, 32'd1);
        chk("t1_ones_cleared", {28'b0, ones}, 32'd0);
        send_frame(8'b1011_0000, 1'b0);
        chk("t1_impar_pulse", {31'b0, fim_impar}, 32'd1);
        chk("t1_busy_in_done", {31'b0, busy}, 32'd0);
        chk("t1_latency", done_cycs[$] - s, 32'd8);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_pulse_one_cycle", {31'b0, fim_impar}, 32'd0);
        chk("t1_idle", {31'b0, busy}, 32'd0);
        chk("t1_ones_held", {28'b0, ones}, 32'd3);
        step(1'b0, 1'b1, 1'b1);
        chk("t1_idle_ignores_valid", {28'b0, ones}, 32'd3);
        chk("t1_idle_stays", {31'b0, busy}, 32'd0);

        // same frame with in_valid low on alternate cycles
        step(1'b1, 1'b0, 1'b0);
        s = cyc;
        send_frame(8'b1011_0000, 1'b1);
        chk("t2_latency", done_cycs[$] - s, 32'd15);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_impar", {30'b0, impar_frames}, 32'd2);
        chk("t2_ones", {28'b0, ones}, 32'd3);

        // abort after 5 bits with start and in=1 in the same cycle
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t3_restart_ones", {28'b0, ones}, 32'd0);
        chk("t3_restart_busy", {31'b0, busy}, 32'd1);
        send_frame(8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_done_count", done_cycs.size(), 32'd3);
        chk("t3_par", {30'b0, par_frames}, 32'd1);
        chk("t3_impar", {30'b0, impar_frames}, 32'd2);

        // asynchronous reset mid-frame
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_ones_mid", {28'b0, ones}, 32'd3);
        chk("t4_busy_mid", {31'b0, busy}, 32'd1);
        #3 rst = 1'b0;
        #4;
        chk("t4_async_busy", {31'b0, busy}, 32'd0);
        chk("t4_async_ones", {28'b0, ones}, 32'd0);
        chk("t4_async_par", {30'b0, par_frames}, 32'd0);
        chk("t4_async_impar", {30'b0, impar_frames}, 32'd0);
        chk("t4_async_done", {31'b0, frame_done}, 32'd0);
        exp_par = 0;
        exp_impar = 0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("t4_stray_busy", {31'b0, busy}, 32'd0);
            chk("t4_stray_ones", {28'b0, ones}, 32'd0);
        end

        // back-to-back even frames, counter saturates at 3
        step(1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            send_frame(8'h00, 1'b0);
            if (f < 4) begin
                step(1'b1, 1'b0, 1'b0);
                chk("t5_b2b_busy", {31'b0, busy}, 32'd1);
            end else begin
                step(1'b0, 1'b0, 1'b0);
            end
        end
        n = done_cycs.size();
        for (int i = 1; i < 5; i++)
            chk("t5_spacing", done_cycs[n-5+i] - done_cycs[n-6+i], 32'd9);
        chk("t5_par_sat", {30'b0, par_frames}, 32'd3);

        // odd frame after saturation of the even counter
        step(1'b1, 1'b0, 1'b0);
        send_frame(8'b0000_0001, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_impar", {30'b0, impar_frames}, 32'd1);
        chk("t6_par_held", {30'b0, par_frames}, 32'd3);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
